// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer for the pipelined MIPS core.
// Drives the PC register's hold (pc_we) and next-PC (npc) inputs: loads the
// reset vector after reset, advances sequentially, applies branch/jump
// redirects, holds on hazard stalls or instruction-memory wait states, and
// buffers a redirect that arrives while the PC is held so it is applied on
// release. A watchdog declares a sticky error if instruction memory stays
// not-ready for TIMEOUT consecutive cycles.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter int          TIMEOUT      = 16,
    parameter int          CNT_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        im_ready,
    output logic        im_req,
    output logic [31:0] npc,
    output logic        pc_we,
    output logic        im_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Last count value before the watchdog trips; ERR is entered from here,
    // so the counter can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg,       state_next;
    logic             pend_valid_reg,  pend_valid_next;
    logic [31:0]      pend_target_reg, pend_target_next;
    logic [CNT_W-1:0] cnt_reg,         cnt_next;
    logic             im_err_reg,      im_err_next;

    logic        rv;
    logic [31:0] rt;
    logic        hold;
    logic [31:0] npc_raw;
    logic        pc_we_c;
    logic        im_req_c;

    // Redirect merge: a jump takes priority over a taken branch.
    assign rv   = jmp_valid | br_taken;
    assign rt   = jmp_valid ? jmp_target : br_target;
    assign hold = stall | ~im_ready;

    // State, pending-redirect buffer, watchdog counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_BOOT;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= 32'h0;
            cnt_reg         <= '0;
            im_err_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
            cnt_reg         <= cnt_next;
            im_err_reg      <= im_err_next;
        end
    end

    // Next-state logic and PC-register control outputs.
    always_comb begin
        state_next       = state_reg;
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        cnt_next         = cnt_reg;
        im_err_next      = im_err_reg;
        npc_raw          = pc;
        pc_we_c          = 1'b1;
        im_req_c         = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                npc_raw          = RESET_VECTOR;
                pc_we_c          = 1'b0;
                state_next       = ST_RUN;
                pend_valid_next  = 1'b0;
                pend_target_next = 32'h0;
                cnt_next         = '0;
            end

            ST_RUN: begin
                im_req_c = 1'b1;
                if (hold) begin
                    // PC frozen; npc kept stable at the current PC.
                    pc_we_c = 1'b1;
                    npc_raw = pc;
                    if (rv) begin
                        // Newest redirect wins over any older buffered one.
                        pend_valid_next  = 1'b1;
                        pend_target_next = rt;
                    end
                end else begin
                    pc_we_c = 1'b0;
                    if (rv) begin
                        npc_raw = rt;
                    end else if (pend_valid_reg) begin
                        npc_raw = pend_target_reg;
                    end else begin
                        npc_raw = pc_next;
                    end
                    pend_valid_next = 1'b0;
                end

                // Watchdog counts only memory wait cycles, not stalls.
                if (!im_ready) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next  = ST_ERR;
                        im_err_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = '0;
                end
            end

            ST_ERR: begin
                // Dead until reset: PC held, no fetches, error asserted.
                pc_we_c     = 1'b1;
                im_req_c    = 1'b0;
                im_err_next = 1'b1;
            end

            default: begin
                // Unused encoding: restart the boot sequence.
                state_next = ST_BOOT;
            end
        endcase
    end

    // Word alignment: upper bits pass through, the low two are tied off so a
    // misaligned target is truncated to its word.
    genvar gi;
    generate
        for (gi = 2; gi < 32; gi++) begin : g_npc_bit
            assign npc[gi] = npc_raw[gi];
        end
    endgenerate
    assign npc[1:0] = 2'b00;

    logic unused_npc_low;
    assign unused_npc_low = ^npc_raw[1:0];

    assign pc_we  = pc_we_c;
    assign busy   = pc_we_c;
    assign im_req = im_req_c;
    assign im_err = im_err_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl,
// checked against a transaction-level model of the fetch rules. The bench
// also plays the PC register (loads npc when pc_we=0).
module tb_fetch_ctrl;

    localparam logic [31:0] RV      = 32'h0000_3000;
    localparam int          TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    logic        im_ready = 1'b1;
    logic [31:0] pc_r;
    logic [31:0] pc_next;
    logic        im_req, pc_we, im_err, busy;
    logic [31:0] npc;

    int n_cmp = 0;
    int n_fail = 0;

    fetch_ctrl #(.RESET_VECTOR(RV), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc_r), .pc_next(pc_next),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target), .im_ready(im_ready),
        .im_req(im_req), .npc(npc), .pc_we(pc_we), .im_err(im_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // PC register: hold when pc_we=1, otherwise load npc.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_r <= 32'h0;
        else if (!pc_we) pc_r <= npc;
    end
    assign pc_next = pc_r + 32'd4;

    // Reference model state (fetch rules, not the RTL's encoding).
    bit          m_boot;
    bit          m_err;
    int          m_idle;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    // Expected / observed values of the most recent cycle.
    logic        exp_we, exp_req, exp_err, npc_care;
    logic [31:0] exp_npc;
    logic        obs_we, obs_req, obs_err, obs_busy;
    logic [31:0] obs_npc;

    // One clock cycle: apply inputs at the falling edge, sample outputs,
    // advance the model, cross the rising edge, return at the next falling edge.
    task automatic cyc(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic r);
        logic        rv;
        logic [31:0] rt;
        logic [31:0] nxt;
        stall = s; br_taken = b; br_target = bt;
        jmp_valid = j; jmp_target = jt; im_ready = r;
        #1;
        obs_we = pc_we; obs_req = im_req; obs_err = im_err;
        obs_busy = busy; obs_npc = npc;
        rv  = b | j;
        rt  = j ? jt : bt;
        nxt = m_pc;
        exp_err  = m_err;
        npc_care = 1'b0;
        exp_npc  = 32'h0;
        if (m_boot) begin
            exp_we = 1'b0; exp_req = 1'b0;
            exp_npc = RV; npc_care = 1'b1; nxt = RV;
            m_boot = 1'b0;
        end else if (m_err) begin
            exp_we = 1'b1; exp_req = 1'b0;
        end else begin
            exp_req = 1'b1;
            exp_we  = s | ~r;
            if (exp_we) begin
                if (rv) m_pend.push_back(rt);
            end else begin
                if (rv) exp_npc = rt;
                else if (m_pend.size() > 0) exp_npc = m_pend[$];
                else exp_npc = m_pc + 32'd4;
                exp_npc = exp_npc & 32'hFFFF_FFFC;
                npc_care = 1'b1;
                nxt = exp_npc;
                m_pend.delete();
            end
            if (!r) begin
                m_idle++;
                if (m_idle >= TIMEOUT) m_err = 1'b1;
            end else begin
                m_idle = 0;
            end
        end
        @(posedge clk);
        #1;
        m_pc = nxt;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    // Reset pulse starting at a falling edge; samples outputs while in reset.
    task automatic do_reset();
        stall = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0; im_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        obs_we = pc_we; obs_req = im_req; obs_err = im_err;
        obs_busy = busy; obs_npc = npc;
        m_boot = 1'b1; m_err = 1'b0; m_idle = 0; m_pc = 32'h0; m_pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL rst_pc_we: got %b want 0", obs_we); end
        n_cmp++; if (obs_npc !== RV) begin n_fail++; $display("FAIL rst_npc: got %h want %h", obs_npc, RV); end
        n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rst_im_req: got %b want 0", obs_req); end
        n_cmp++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", obs_busy); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rst_im_err: got %b want 0", obs_err); end
        $display("reset: we=%b npc=%h req=%b busy=%b err=%b", obs_we, obs_npc, obs_req, obs_busy, obs_err);
    endtask

    task automatic test_sequential();
        logic [31:0] want[3];
        want[0] = 32'h3000; want[1] = 32'h3004; want[2] = 32'h3008;
        for (int i = 0; i < 3; i++) begin
            idle();
            n_cmp++; if (pc_r !== want[i]) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_r, want[i]); end
            n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL seq_we%0d: got %b want 0", i, obs_we); end
            $display("seq: pc=%h we=%b req=%b", pc_r, obs_we, obs_req);
        end
        n_cmp++; if (obs_req !== 1'b1) begin n_fail++; $display("FAIL seq_req: got %b want 1", obs_req); end
    endtask

    task automatic test_redirect();
        cyc(1'b0, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (pc_r !== 32'h3040) begin n_fail++; $display("FAIL br_pc: got %h want 00003040", pc_r); end
        $display("branch: pc=%h", pc_r);
        cyc(1'b0, 1'b1, 32'h3500, 1'b1, 32'h3100, 1'b1);
        n_cmp++; if (pc_r !== 32'h3100) begin n_fail++; $display("FAIL jmp_prio_pc: got %h want 00003100", pc_r); end
        $display("jump+branch: pc=%h", pc_r);
    endtask

    task automatic test_stall_redirect();
        logic [31:0] p0;
        p0 = pc_r;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, i == 0, 32'h3080, 1'b0, 32'h0, 1'b1);
            n_cmp++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy%0d: got %b want 1", i, obs_busy); end
            n_cmp++; if (pc_r !== p0) begin n_fail++; $display("FAIL stall_frozen%0d: got %h want %h", i, pc_r, p0); end
            $display("stall: pc=%h busy=%b", pc_r, obs_busy);
        end
        idle();
        n_cmp++; if (pc_r !== 32'h3080) begin n_fail++; $display("FAIL stall_release_pc: got %h want 00003080", pc_r); end
        idle();
        n_cmp++; if (pc_r !== 32'h3084) begin n_fail++; $display("FAIL stall_after_pc: got %h want 00003084", pc_r); end
        $display("stall release: pc=%h", pc_r);
    endtask

    task automatic test_double_redirect();
        cyc(1'b1, 1'b1, 32'h3080, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h30C0, 1'b1);
        idle();
        n_cmp++; if (pc_r !== 32'h30C0) begin n_fail++; $display("FAIL overwrite_pc: got %h want 000030c0", pc_r); end
        $display("double redirect: pc=%h", pc_r);
        cyc(1'b1, 1'b1, 32'h3300, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (pc_r !== 32'h3200) begin n_fail++; $display("FAIL live_override_pc: got %h want 00003200", pc_r); end
        idle();
        n_cmp++; if (pc_r !== 32'h3204) begin n_fail++; $display("FAIL pend_cleared_pc: got %h want 00003204", pc_r); end
        $display("live override: pc=%h", pc_r);
    endtask

    task automatic test_watchdog();
        logic [31:0] p0;
        p0 = pc_r;
        repeat (15) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle();
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL wd15_err: got %b want 0", obs_err); end
        n_cmp++; if (pc_r !== p0 + 32'd4) begin n_fail++; $display("FAIL wd15_pc: got %h want %h", pc_r, p0 + 32'd4); end
        $display("wait 15: pc=%h err=%b", pc_r, obs_err);
        p0 = pc_r;
        repeat (16) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 32'h3700, i == 1, 32'h3800, 1'b1);
            n_cmp++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL wd16_err%0d: got %b want 1", i, obs_err); end
            n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL wd16_req%0d: got %b want 0", i, obs_req); end
            n_cmp++; if (pc_r !== p0) begin n_fail++; $display("FAIL wd16_frozen%0d: got %h want %h", i, pc_r, p0); end
            $display("error: pc=%h err=%b req=%b we=%b", pc_r, obs_err, obs_req, obs_we);
        end
        do_reset();
        idle();
        n_cmp++; if (pc_r !== RV) begin n_fail++; $display("FAIL wd_recover_pc: got %h want %h", pc_r, RV); end
        n_cmp++; if (im_err !== 1'b0) begin n_fail++; $display("FAIL wd_recover_err: got %b want 0", im_err); end
        $display("recover: pc=%h err=%b", pc_r, im_err);
    endtask

    task automatic test_reset_mid_hold();
        idle();
        cyc(1'b1, 1'b1, 32'h3480, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_reset();
        n_cmp++; if (obs_npc !== RV) begin n_fail++; $display("FAIL midhold_rst_npc: got %h want %h", obs_npc, RV); end
        idle();
        n_cmp++; if (pc_r !== RV) begin n_fail++; $display("FAIL midhold_boot_pc: got %h want %h", pc_r, RV); end
        idle();
        n_cmp++; if (pc_r !== 32'h3004) begin n_fail++; $display("FAIL midhold_discard_pc: got %h want 00003004", pc_r); end
        cyc(1'b0, 1'b1, 32'h3043, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (obs_npc !== 32'h3040) begin n_fail++; $display("FAIL misalign_npc: got %h want 00003040", obs_npc); end
        n_cmp++; if (pc_r !== 32'h3040) begin n_fail++; $display("FAIL misalign_pc: got %h want 00003040", pc_r); end
        $display("reset mid-hold: pc=%h npc=%h", pc_r, obs_npc);
    endtask

    task automatic test_random();
        int burst;
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            logic s, b, j, r;
            logic [31:0] bt, jt;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                n_cmp++; if (obs_we !== 1'b0 || obs_npc !== RV || obs_req !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_rst: got we=%b npc=%h req=%b want 0/%h/0", obs_we, obs_npc, obs_req, RV);
                end
            end
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(14, 18);
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 5) == 0);
            bt = $urandom();
            jt = $urandom();
            if (burst > 0) begin r = 1'b0; burst--; end
            else r = ($urandom_range(0, 7) != 0);
            cyc(s, b, bt, j, jt, r);
            n_cmp++; if (obs_we !== exp_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b want %b", i, obs_we, exp_we); end
            n_cmp++; if (obs_busy !== exp_we) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, obs_busy, exp_we); end
            n_cmp++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b want %b", i, obs_req, exp_req); end
            n_cmp++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, obs_err, exp_err); end
            if (npc_care) begin
                n_cmp++; if (obs_npc !== exp_npc) begin n_fail++; $display("FAIL rnd_npc[%0d]: got %h want %h", i, obs_npc, exp_npc); end
            end
            n_cmp++; if (pc_r !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_r, m_pc); end
            $display("rnd %0d: s=%b br=%b j=%b rdy=%b we=%b req=%b err=%b pc=%h", i, s, b, j, r, obs_we, obs_req, obs_err, pc_r);
        end
    endtask

    initial begin
        m_boot = 1'b1; m_err = 1'b0; m_idle = 0; m_pc = 32'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_redirect();
        test_double_redirect();
        test_watchdog();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish within budget");
        $fatal(1, "time limit");
    end

endmodule
